shift_register_universal: RTL

- Parametrised successor to the serial-in right shift register.
- Supports right shift, left shift, parallel load and hold, each with its own serial input and serial output.
- A word counter emits a one-cycle strobe each time BITS shifts have completed since the last load or clear.
- Used as the common serialiser/deserialiser for the VGA-side and peripheral-side bit streams.

---
 rtl/shift_register_universal_pkg.sv | 15 +
 rtl/shift_register_universal_mod_counter.sv | 43 ++++
 rtl/shift_register_universal.sv | 81 ++++++++
 3 files changed

// File: rtl/shift_register_universal_pkg.sv
// Shared definitions for the universal shift register.
//   - i_mode encodings (hold / shift right / shift left / parallel load)
//   - cnt_width(): width of a counter that holds the values 0..bits
package shift_register_universal_pkg;

  localparam logic [1:0] SR_HOLD  = 2'b00;
  localparam logic [1:0] SR_RIGHT = 2'b01;
  localparam logic [1:0] SR_LEFT  = 2'b10;
  localparam logic [1:0] SR_LOAD  = 2'b11;

  function automatic int cnt_width(input int bits);
    return $clog2(bits + 1);
  endfunction

endpackage

// File: rtl/shift_register_universal_mod_counter.sv
// mod_counter: modulo-MOD up counter with a registered wrap pulse.
// Ports:
//   clk      system clock
//   i_rst_n  asynchronous active-low reset
//   i_sclr   synchronous clear (count to 0, no wrap pulse)
//   i_inc    advance the count by one
//   o_cnt    current count, 0..MOD-1
//   o_wrap   high for the one cycle after the count wrapped MOD-1 -> 0
module mod_counter #(
  parameter int MOD = 5,
  parameter int W   = 3
) (
  input  logic         clk,
  input  logic         i_rst_n,
  input  logic         i_sclr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt,
  output logic         o_wrap
);

  localparam logic [W-1:0] LAST = W'(MOD - 1);

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_cnt  <= '0;
      o_wrap <= 1'b0;
    end else if (i_sclr) begin
      o_cnt  <= '0;
      o_wrap <= 1'b0;
    end else if (i_inc) begin
      if (o_cnt == LAST) begin
        o_cnt  <= '0;
        o_wrap <= 1'b1;
      end else begin
        o_cnt  <= o_cnt + 1'b1;
        o_wrap <= 1'b0;
      end
    end else begin
      o_wrap <= 1'b0;
    end
  end

endmodule

// File: rtl/shift_register_universal.sv
// shift_register_universal: BITS-wide register with hold, right shift,
// left shift and parallel load, plus a word counter that strobes once
// every BITS shifts since the last load or clear. BITS must be >= 2.
// Ports:
//   clk           system clock
//   i_rst_n       asynchronous active-low reset
//   i_sclr        synchronous clear (beats enable and mode)
//   i_en          clock enable for mode operations
//   i_mode        00 hold, 01 shift right, 10 shift left, 11 load
//   i_dat_r       serial in at the MSB on a right shift
//   i_dat_l       serial in at the LSB on a left shift
//   i_load        parallel load value
//   o_data        register contents
//   o_sout_r      o_data[0], bit lost on the next right shift
//   o_sout_l      o_data[BITS-1], bit lost on the next left shift
//   o_cnt         shifts completed in the current word
//   o_word_valid  one-cycle strobe after the BITS-th shift of a word
module shift_register_universal
  import shift_register_universal_pkg::*;
#(
  parameter int              BITS      = 5,
  parameter logic [BITS-1:0] RESET_VAL = '0,
  parameter int              CNT_W     = cnt_width(BITS)
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic             i_sclr,
  input  logic             i_en,
  input  logic [1:0]       i_mode,
  input  logic             i_dat_r,
  input  logic             i_dat_l,
  input  logic [BITS-1:0]  i_load,
  output logic [BITS-1:0]  o_data,
  output logic             o_sout_r,
  output logic             o_sout_l,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_word_valid
);

  logic do_shift;
  logic do_load;
  logic cnt_clr;

  assign do_shift = i_en && ((i_mode == SR_RIGHT) || (i_mode == SR_LEFT));
  assign do_load  = i_en && (i_mode == SR_LOAD);

  // A load restarts the word, so it clears the counter on the same edge
  // and suppresses any wrap that would otherwise have happened.
  assign cnt_clr  = i_sclr || do_load;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_data <= RESET_VAL;
    end else if (i_sclr) begin
      o_data <= RESET_VAL;
    end else if (i_en) begin
      case (i_mode)
        SR_RIGHT: o_data <= {i_dat_r, o_data[BITS-1:1]};
        SR_LEFT:  o_data <= {o_data[BITS-2:0], i_dat_l};
        SR_LOAD:  o_data <= i_load;
        default:  o_data <= o_data;
      endcase
    end
  end

  mod_counter #(
    .MOD (BITS),
    .W   (CNT_W)
  ) u_word_cnt (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .i_sclr  (cnt_clr),
    .i_inc   (do_shift),
    .o_cnt   (o_cnt),
    .o_wrap  (o_word_valid)
  );

  assign o_sout_r = o_data[0];
  assign o_sout_l = o_data[BITS-1];

endmodule
